// File: rtl/counter_pkg.sv
// counter_pkg: shared defaults and driver state encoding for the up-counter block
package counter_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} drv_state_t;
endpackage

// File: rtl/count_driver_if.sv
// count_driver_if: burst command, counter strobe and check-result bundle
interface count_driver_if #(parameter int WIDTH = 8, parameter int GAP_W = 4);
  logic             start;
  logic [WIDTH-1:0] burst_len;
  logic [GAP_W-1:0] gap;
  logic [WIDTH-1:0] i_count;
  logic             count_en;
  logic             count_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] o_issued;
  logic             mismatch;
  modport master (input start, burst_len, gap, i_count,
                  output count_en, count_valid, busy, done, o_issued, mismatch);
  modport slave (output start, burst_len, gap, i_count,
                 input count_en, count_valid, busy, done, o_issued, mismatch);
endinterface

// File: rtl/count_gap_timer.sv
// count_gap_timer: loadable down-counter flagging the last idle cycle of a gap
module count_gap_timer import counter_pkg::*; #(parameter int GAP_W = DEF_GAP_W) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [GAP_W-1:0] value,
  output logic             expired
);
  logic [GAP_W-1:0] cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= load ? value : cnt != '0 ? cnt - GAP_W'(1) : cnt;
  assign expired = cnt == GAP_W'(1);
endmodule

// File: rtl/count_driver.sv
// count_driver: issues a burst of counter increment strobes and checks the returned count.
// COUNT_DRIVER_CHECK_EN enables the base snapshot and comparator; otherwise mismatch is 0.
module count_driver import counter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP_W = DEF_GAP_W
) (
  input logic            clk,
  input logic            resetn,
  count_driver_if.master bus
);
  drv_state_t       state;
  logic [WIDTH-1:0] len;
  logic [GAP_W-1:0] g;
  logic             last, load, expired;
  assign last = bus.o_issued + WIDTH'(1) == len;
  assign load = state == ISSUE && !last && g != '0;
  count_gap_timer #(.GAP_W(GAP_W)) u_timer (
    .clk(clk), .resetn(resetn), .load(load), .value(g), .expired(expired)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      len <= '0;
      g <= '0;
      bus.count_en <= 1'b0;
      bus.count_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.o_issued <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          len <= bus.burst_len;
          g <= bus.gap;
          bus.o_issued <= '0;
          bus.busy <= 1'b1;
          bus.count_en <= 1'b1;
          bus.count_valid <= bus.burst_len != '0;
          state <= bus.burst_len == '0 ? CHECK : ISSUE;
        end
        ISSUE: begin
          bus.o_issued <= bus.o_issued + WIDTH'(1);
          bus.count_valid <= !last && g == '0;
          state <= last ? CHECK : g == '0 ? ISSUE : WAIT;
        end
        WAIT: if (expired) begin
          bus.count_valid <= 1'b1;
          state <= ISSUE;
        end
        CHECK: begin
          bus.busy <= 1'b0;
          bus.count_en <= 1'b0;
          bus.done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef COUNT_DRIVER_CHECK_EN
  logic [WIDTH-1:0] base;
  // CHECK sees i_count after the final strobe's increment has landed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base <= '0;
      bus.mismatch <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      base <= bus.i_count;
      bus.mismatch <= 1'b0;
    end else if (state == CHECK) begin
      bus.mismatch <= bus.i_count != base + len;
    end
  end
`else
  assign bus.mismatch = 1'b0;
`endif
endmodule

// File: doc/count_driver.md
# count_driver

Request-side initiator for the enable/valid increment interface of the up-counter block. On a start command it issues a programmed burst of single-cycle increment strobes with a programmable inter-strobe gap, then checks the counter's returned value against the expected total. It sits between the test and control logic and the counter instance, and is the producer of the counter's `count_en`/`count_valid` inputs.

## Interface
- `WIDTH`, 8: width of the burst length, issued count, and returned counter value; must match the counter's `WIDTH`.
- `GAP_W`, 4: width of the gap field; the gap ranges from 0 to 2^GAP_W−1 idle cycles between strobes.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle burst request; sampled only in IDLE.
- `burst_len`  in  WIDTH  number of strobes; latched on accepted `start`.
- `gap`  in  GAP_W  idle cycles between strobes; latched on accepted `start`.
- `i_count`  in  WIDTH  counter's `o_count`, returned for checking.
- `count_en`  out  1  drives the counter enable; high throughout ISSUE/WAIT/CHECK.
- `count_valid`  out  1  drives the counter strobe; one-cycle pulse per increment.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at burst completion.
- `o_issued`  out  WIDTH  strobes issued in the current or last burst.
- `mismatch`  out  1  check result; sticky until the next accepted `start`.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK.
- **IDLE**
  - On `start` = 1: latch `burst_len` → L and `gap` → G; snapshot `i_count` → base; clear `o_issued` and `mismatch`.
  - Then go to ISSUE, or to CHECK if L = 0.
- **ISSUE**
  - `count_valid` = 1 for exactly one cycle; `o_issued` increments.
  - If `o_issued`+1 = L, go to CHECK.
  - Else if G = 0, stay in ISSUE (back-to-back strobes).
  - Else go to WAIT.
- **WAIT**
  - Runs G cycles with `count_valid` = 0, then returns to ISSUE.
- **CHECK**
  - Lasts one cycle. Compares `i_count` against (base + L) mod 2^WIDTH.
  - Sets `mismatch` on inequality. Goes to IDLE with `done` = 1.
- All arithmetic is modulo 2^WIDTH; counter wrap (e.g. base = 8'hFE, L = 3 → expect 8'h01) is not an error.
- `start` while `busy` = 1 is ignored and has no side effects.
- `count_en` = `busy`. `count_valid` never asserts outside ISSUE.
- All outputs are registered.

## Timing
- Reset value is 0 for every output (`count_en`, `count_valid`, `busy`, `done`, `o_issued`, `mismatch`). State returns to IDLE asynchronously on `resetn` low, including mid-burst; no partial strobe is emitted after reset is asserted.
- `start` accepted at the edge ending cycle 0: `busy` and `count_en` rise in cycle 1.
- Strobe k (1-based) occurs in cycle 1 + (k−1)(G+1).
- The last strobe is in cycle T = 1 + (L−1)(G+1). CHECK is in cycle T+1, where `i_count` already reflects the final increment.
- `done` and a valid `mismatch` appear in cycle T+2, with `busy` = 0. A new `start` is accepted in that same cycle.
- L = 0: CHECK in cycle 1, `done` in cycle 2, no strobes.
- Total latency from `start` to `done` = L(G+1) − G + 2 cycles for L ≥ 1.

## Configuration
- `COUNT_DRIVER_CHECK_EN` defined: comparator and base snapshot are present; `mismatch` behaves as specified.
- Undefined: comparator and base register are removed; `mismatch` is tied to 0. The CHECK state and all cycle timing are unchanged.

## Structure
- Shared package `counter_pkg`:
  - default `WIDTH` and `GAP_W` constants;
  - `drv_state_t` enum (IDLE, ISSUE, WAIT, CHECK).
- One sub-module, `count_gap_timer`: GAP_W down-counter with `load`/`value` inputs, asserting `expired` after G cycles. It is used by the WAIT state.
- Top level contains the FSM, the `o_issued` counter, the base register and the comparator.

## Test plan
- Reset mid-burst: L = 10, G = 2, assert `resetn` low during WAIT → all outputs 0 immediately; after release, the FSM is in IDLE and the next `start` works normally.
- Back-to-back: base 0, L = 4, G = 0 → `count_valid` high in cycles 1–4, CHECK in cycle 5, `done` in cycle 6, `o_issued` = 4, `mismatch` = 0, `i_count` = 4.
- Gapped wrap: base 8'hFE, L = 3, G = 3 → strobes in cycles 1, 5, 9; `done` in cycle 11; `i_count` = 8'h01; `mismatch` = 0.
- Zero-length and ignored start: L = 0 → no strobes, `done` in cycle 2. Pulse `start` again while `busy` in a L = 5 burst → ignored; `o_issued` ends at 5.
- Fault injection (with `COUNT_DRIVER_CHECK_EN`): hold the counter's `count_valid` input low on the 2nd strobe, L = 3 → `mismatch` = 1 at `done` and held until the next `start`. Without the macro, `mismatch` stays 0.
